// File: rtl/flit_pkg.sv
// ----------------------------------------------------------------------------
// flit_pkg
// Shared definitions for the flit transmitter: flit type codes, flit field
// positions, the downstream FIFO depth, the transmitter state encoding and
// helpers that assemble the 31-bit flit body (everything except bit 31).
// ----------------------------------------------------------------------------
package flit_pkg;

   // Flit type codes carried in [TYPE_HI:TYPE_LO]; 2'b00 is never sent
   localparam logic [1:0] FLIT_HEAD = 2'b01;
   localparam logic [1:0] FLIT_BODY = 2'b10;
   localparam logic [1:0] FLIT_TAIL = 2'b11;

   // Field positions inside a flit
   localparam int TYPE_HI = 30;
   localparam int TYPE_LO = 29;
   localparam int DEST_HI = 28;
   localparam int DEST_LO = 25;
   localparam int LEN_HI  = 24;
   localparam int LEN_LO  = 20;
   localparam int SRC_HI  = 19;
   localparam int SRC_LO  = 16;

   // Depth of the downstream router input FIFO fed by this channel
   localparam int FIFO_DEPTH = 6;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PAYLOAD = 1'b1
   } tx_state_e;

   // Header flit without bit 31: type, dest, len, source id, low half zero
   function automatic logic [30:0] make_header(input logic [3:0] dest,
                                               input logic [4:0] len,
                                               input logic [3:0] src);
      logic [30:0] f;
      f                   = '0;
      f[TYPE_HI:TYPE_LO]  = FLIT_HEAD;
      f[DEST_HI:DEST_LO]  = dest;
      f[LEN_HI:LEN_LO]    = len;
      f[SRC_HI:SRC_LO]    = src;
      return f;
   endfunction

   // Body or tail flit without bit 31: type code over the payload word
   function automatic logic [30:0] make_data(input logic [1:0]  typ,
                                             input logic [28:0] data);
      return {typ, data};
   endfunction

endpackage

// File: rtl/flit_out_stage.sv
// ----------------------------------------------------------------------------
// flit_out_stage
// One-entry registered output stage in front of the downstream FIFO write
// port. Holds dout/in_val while the FIFO reports full, clears in_val once the
// flit is delivered, and reports out_free so a new flit can be loaded on the
// same edge the current one leaves (no bubbles).
//
// Optional feature (macro FLIT_PARITY_EN): when defined, dout[31] carries even
// parity over dout[30:0], computed at load time. When undefined, dout[31] is
// tied to 0.
//
// Ports:
//   clk_i       clock
//   reset_i     synchronous active-high reset
//   load_i      load flit_i this edge (only honoured when out_free_o)
//   flit_i      flit bits [30:0] to load
//   full_ext_i  downstream FIFO full
//   out_free_o  stage empty or its flit is delivered this edge
//   in_val_o    registered flit valid
//   dout_o      registered flit
// ----------------------------------------------------------------------------
module flit_out_stage (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        load_i,
   input  logic [30:0] flit_i,
   input  logic        full_ext_i,
   output logic        out_free_o,
   output logic        in_val_o,
   output logic [31:0] dout_o
);

   logic        in_val_q, in_val_d;
   logic [31:0] dout_q, dout_d;
   logic        par_bit;

`ifdef FLIT_PARITY_EN
   // Even parity: total number of ones across all 32 bits is even
   assign par_bit = ^flit_i;
`else
   assign par_bit = 1'b0;
`endif

   // Free when empty, or when the held flit transfers on this edge
   assign out_free_o = !in_val_q || !full_ext_i;

   always_comb begin
      in_val_d = in_val_q;
      dout_d   = dout_q;
      if (load_i && out_free_o) begin
         in_val_d = 1'b1;
         dout_d   = {par_bit, flit_i};
      end else if (out_free_o) begin
         // Delivered (or already empty) with nothing new: drop valid, keep data
         in_val_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         in_val_q <= 1'b0;
         dout_q   <= 32'h0;
      end else begin
         in_val_q <= in_val_d;
         dout_q   <= dout_d;
      end
   end

   assign in_val_o = in_val_q;
   assign dout_o   = dout_q;

endmodule

// File: rtl/flit_tx_channel.sv
// ----------------------------------------------------------------------------
// flit_tx_channel
// Output-channel transmitter: turns a packet request plus a payload stream
// into header/body/tail flits and pushes them into the downstream router's
// input FIFO through a one-entry registered output stage. One packet in
// flight; sustains one flit per cycle while the FIFO is not full, including
// across packet boundaries.
//
// Optional feature (macro FLIT_PARITY_EN): even parity in dout[31], handled
// inside flit_out_stage.
//
// Parameters:
//   SRC_ID   source router id placed in header [19:16]
//   MAX_LEN  largest legal payload length (1..31)
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pkt_req/dest/len    packet request (held until pkt_ack)
//   pkt_ack, err_len    request consumed / rejected for illegal length
//   pl_data/val/rdy     payload stream handshake
//   full_ext            downstream FIFO full
//   dout, in_val        registered flit and valid to downstream
//   busy                packet in progress or flit pending
// ----------------------------------------------------------------------------
module flit_tx_channel
   import flit_pkg::*;
#(
   parameter logic [3:0] SRC_ID  = 4'd0,
   parameter int         MAX_LEN = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pkt_req,
   input  logic [3:0]  pkt_dest,
   input  logic [4:0]  pkt_len,
   output logic        pkt_ack,
   output logic        err_len,
   input  logic [28:0] pl_data,
   input  logic        pl_val,
   output logic        pl_rdy,
   input  logic        full_ext,
   output logic [31:0] dout,
   output logic        in_val,
   output logic        busy
);

   localparam logic [4:0] MAX_LEN_L = 5'(MAX_LEN);

   tx_state_e   state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        out_free;
   logic        load;
   logic [30:0] flit;
   logic        len_ok;

   assign len_ok = (pkt_len != 5'd0) && (pkt_len <= MAX_LEN_L);

   // State and remaining-payload counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (pkt_req && len_ok && out_free) state_d = ST_PAYLOAD;
         ST_PAYLOAD: if (pl_val && out_free && cnt_q == 5'd1) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Outputs, flit selection and counter update. Handshake outputs are
   // combinational so a held request is consumed exactly once; they are
   // forced low while reset is asserted.
   always_comb begin
      pkt_ack = 1'b0;
      err_len = 1'b0;
      pl_rdy  = 1'b0;
      load    = 1'b0;
      flit    = '0;
      cnt_d   = cnt_q;
      if (!reset) begin
         case (state_q)
            ST_IDLE: begin
               if (pkt_req) begin
                  if (!len_ok) begin
                     // Rejected requests do not need the output stage
                     pkt_ack = 1'b1;
                     err_len = 1'b1;
                  end else if (out_free) begin
                     pkt_ack = 1'b1;
                     load    = 1'b1;
                     flit    = make_header(pkt_dest, pkt_len, SRC_ID);
                     cnt_d   = pkt_len;
                  end
               end
            end
            ST_PAYLOAD: begin
               pl_rdy = out_free;
               if (pl_val && out_free) begin
                  load  = 1'b1;
                  flit  = make_data((cnt_q == 5'd1) ? FLIT_TAIL : FLIT_BODY,
                                    pl_data);
                  cnt_d = cnt_q - 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   flit_out_stage u_out (
      .clk_i      (clk),
      .reset_i    (reset),
      .load_i     (load),
      .flit_i     (flit),
      .full_ext_i (full_ext),
      .out_free_o (out_free),
      .in_val_o   (in_val),
      .dout_o     (dout)
   );

   assign busy = (state_q == ST_PAYLOAD) || in_val;

endmodule

// File: tb/tb_flit_tx_channel.sv
module tb_flit_tx_channel;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, pkt_req, pl_val, full_ext;
   logic [3:0]  pkt_dest;
   logic [4:0]  pkt_len;
   logic [28:0] pl_data;
   logic        pkt_ack, err_len, pl_rdy, in_val, busy;
   logic [31:0] dout;

   int n_cmp = 0;
   int n_bad = 0;

   flit_tx_channel #(.SRC_ID(4'd2), .MAX_LEN(16)) dut (
      .clk(clk), .reset(reset), .pkt_req(pkt_req), .pkt_dest(pkt_dest),
      .pkt_len(pkt_len), .pkt_ack(pkt_ack), .err_len(err_len),
      .pl_data(pl_data), .pl_val(pl_val), .pl_rdy(pl_rdy),
      .full_ext(full_ext), .dout(dout), .in_val(in_val), .busy(busy)
   );

   // Full 32-bit flit as expected on dout, including bit 31
   function automatic logic [31:0] fin(input logic [30:0] f);
`ifdef FLIT_PARITY_EN
      return {^f, f};
`else
      return {1'b0, f};
`endif
   endfunction

   function automatic logic [30:0] hdr(input logic [3:0] d, input logic [4:0] l);
      return {2'b01, d, l, 4'd2, 16'h0};
   endfunction

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        rst, req;
      logic [3:0]  dest;
      logic [4:0]  len;
      logic        pv;
      logic [28:0] pd;
      logic        fe;
      logic        ack, err, rdy;   // combinational, before the edge
      logic        iv, bsy;         // registered, after the edge
      logic [30:0] fl;              // dout[30:0] after the edge
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic rst, input logic req, input logic [3:0] dest,
                               input logic [4:0] len, input logic pv, input logic [28:0] pd,
                               input logic fe, input logic ack, input logic err,
                               input logic rdy, input logic iv, input logic bsy,
                               input logic [30:0] fl);
      vec_t v;
      v.rst = rst; v.req = req; v.dest = dest; v.len = len; v.pv = pv; v.pd = pd;
      v.fe = fe; v.ack = ack; v.err = err; v.rdy = rdy; v.iv = iv; v.bsy = bsy;
      v.fl = fl;
      return v;
   endfunction

   localparam logic [28:0] D1 = 29'h0AAAAAAA;
   localparam logic [28:0] D2 = 29'h15555555;
   localparam logic [28:0] D3 = 29'h00000001;

   // Random-phase state
   logic [30:0] expq[$];
   logic [28:0] words[$];
   logic [3:0]  pdest;
   logic [4:0]  plen5;
   int          phase, wi, npkt, cyc;
   logic        mv, legal, exp_free, exp_rdy, acc, ld;

   task automatic new_pkt();
      pdest = 4'($urandom);
      plen5 = 5'($urandom_range(0, 20));
      words.delete();
      for (int k = 0; k < int'(plen5); k++) words.push_back(29'($urandom));
   endtask

   initial begin
      reset = 1'b1; pkt_req = 1'b1; pkt_dest = 4'd5; pkt_len = 5'd3;
      pl_val = 1'b1; pl_data = D1; full_ext = 1'b0;

      // Reset state, with a request and payload pending
      repeat (2) @(posedge clk);
      #1;
      chk1 ("rst_in_val", in_val, 1'b0);
      chk32("rst_dout", dout, 32'h0);
      chk1 ("rst_busy", busy, 1'b0);
      @(negedge clk);
      chk1 ("rst_ack", pkt_ack, 1'b0);
      chk1 ("rst_err", err_len, 1'b0);
      chk1 ("rst_rdy", pl_rdy, 1'b0);
      @(posedge clk);
      #1;

      // Directed vectors
      // basic len 3 packet: header 0x2A320000, body, body, tail
      tv.push_back(mk(0,1,5,3,1,D1,0, 1,0,0, 1,1, hdr(5,3)));
      tv.push_back(mk(0,0,5,3,1,D1,0, 0,0,1, 1,1, {2'b10,D1}));
      tv.push_back(mk(0,0,5,3,1,D2,0, 0,0,1, 1,1, {2'b10,D2}));
      tv.push_back(mk(0,0,5,3,1,D3,0, 0,0,1, 1,1, {2'b11,D3}));
      tv.push_back(mk(0,0,5,3,0,D3,0, 0,0,0, 0,0, {2'b11,D3}));
      // stall 4 cycles with first body on dout
      tv.push_back(mk(0,1,5,3,0,D1,0, 1,0,0, 1,1, hdr(5,3)));
      tv.push_back(mk(0,0,5,3,1,D1,0, 0,0,1, 1,1, {2'b10,D1}));
      for (int k = 0; k < 4; k++)
         tv.push_back(mk(0,0,5,3,1,D2,1, 0,0,0, 1,1, {2'b10,D1}));
      tv.push_back(mk(0,0,5,3,1,D2,0, 0,0,1, 1,1, {2'b10,D2}));
      tv.push_back(mk(0,0,5,3,1,D3,0, 0,0,1, 1,1, {2'b11,D3}));
      tv.push_back(mk(0,0,5,3,0,D3,0, 0,0,0, 0,0, {2'b11,D3}));
      // illegal lengths 0 and 20
      tv.push_back(mk(0,1,5,0,0,D1,0, 1,1,0, 0,0, {2'b11,D3}));
      tv.push_back(mk(0,1,5,20,0,D1,0, 1,1,0, 0,0, {2'b11,D3}));
      tv.push_back(mk(0,0,5,3,0,D1,0, 0,0,0, 0,0, {2'b11,D3}));
      // back-to-back len 1 then len 2
      tv.push_back(mk(0,1,3,1,0,D1,0, 1,0,0, 1,1, hdr(3,1)));
      tv.push_back(mk(0,1,7,2,1,D1,0, 0,0,1, 1,1, {2'b11,D1}));
      tv.push_back(mk(0,1,7,2,0,D1,0, 1,0,0, 1,1, hdr(7,2)));
      tv.push_back(mk(0,0,7,2,1,D2,0, 0,0,1, 1,1, {2'b10,D2}));
      tv.push_back(mk(0,0,7,2,1,D3,0, 0,0,1, 1,1, {2'b11,D3}));
      tv.push_back(mk(0,0,7,2,0,D3,0, 0,0,0, 0,0, {2'b11,D3}));
      // reset after the second flit of a len 4 packet, then a fresh packet
      tv.push_back(mk(0,1,9,4,0,D1,0, 1,0,0, 1,1, hdr(9,4)));
      tv.push_back(mk(0,0,9,4,1,D1,0, 0,0,1, 1,1, {2'b10,D1}));
      tv.push_back(mk(1,1,9,4,1,D2,0, 0,0,0, 0,0, 31'h0));
      tv.push_back(mk(0,1,9,1,0,D2,0, 1,0,0, 1,1, hdr(9,1)));
      tv.push_back(mk(0,0,9,1,1,D3,0, 0,0,1, 1,1, {2'b11,D3}));
      tv.push_back(mk(0,0,9,1,0,D3,0, 0,0,0, 0,0, {2'b11,D3}));

      foreach (tv[i]) begin
         reset = tv[i].rst; pkt_req = tv[i].req; pkt_dest = tv[i].dest;
         pkt_len = tv[i].len; pl_val = tv[i].pv; pl_data = tv[i].pd;
         full_ext = tv[i].fe;
         @(negedge clk);
         chk1("vec_ack", pkt_ack, tv[i].ack);
         chk1("vec_err", err_len, tv[i].err);
         chk1("vec_rdy", pl_rdy, tv[i].rdy);
         @(posedge clk);
         #1;
         chk1 ("vec_in_val", in_val, tv[i].iv);
         chk1 ("vec_busy", busy, tv[i].bsy);
         chk32("vec_dout", dout, (tv[i].rst ? 32'h0 : fin(tv[i].fl)));
      end

      // Hand-written: header value is the documented constant
      pkt_req = 1'b1; pkt_dest = 4'd5; pkt_len = 5'd3; pl_val = 1'b0;
      @(posedge clk);
      #1;
      pkt_req = 1'b0;
      chk32("hdr_const", {1'b0, dout[30:0]}, 32'h2A320000);
      // drain that packet
      pl_val = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      pl_val = 1'b0;
      @(posedge clk);
      #1;
      chk1("hdr_drain_busy", busy, 1'b0);

      // Randomised traffic against a queue-based model
      phase = 0; npkt = 0; cyc = 0; mv = 1'b0;
      new_pkt();
      while ((npkt < 40 || phase == 1 || expq.size() > 0) && cyc < 6000) begin
         full_ext = ($urandom_range(0, 9) < 3);
         pkt_req  = (phase == 0 && npkt < 40);
         pkt_dest = pdest;
         pkt_len  = plen5;
         pl_val   = (phase == 1) && ($urandom_range(0, 3) != 0);
         pl_data  = (phase == 1) ? words[wi] : 29'($urandom);
         @(negedge clk);
         exp_free = !mv || !full_ext;
         ld = 1'b0;
         chk1("rnd_in_val", in_val, mv);
         if (mv && !full_ext) begin
            if (expq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL rnd_extra: unexpected flit %h", dout);
            end else begin
               chk32("rnd_flit", dout, fin(expq.pop_front()));
            end
         end
         if (phase == 0) begin
            chk1("rnd_rdy_idle", pl_rdy, 1'b0);
            if (pkt_req) begin
               legal = (plen5 >= 5'd1) && (plen5 <= 5'd16);
               chk1("rnd_ack", pkt_ack, legal ? exp_free : 1'b1);
               chk1("rnd_err", err_len, !legal);
               if (!legal || exp_free) begin
                  if (legal) begin
                     expq.push_back(hdr(pdest, plen5));
                     foreach (words[k])
                        expq.push_back({(k == words.size() - 1) ? 2'b11 : 2'b10, words[k]});
                     phase = 1; wi = 0; ld = 1'b1;
                  end
                  npkt++;
                  if (!legal) new_pkt();
               end
            end else begin
               chk1("rnd_ack_idle", pkt_ack, 1'b0);
            end
         end else begin
            exp_rdy = exp_free;
            chk1("rnd_rdy", pl_rdy, exp_rdy);
            chk1("rnd_ack_pay", pkt_ack, 1'b0);
            acc = pl_val && exp_rdy;
            if (acc) begin
               ld = 1'b1;
               wi++;
               if (wi == words.size()) begin
                  phase = 0;
                  new_pkt();
               end
            end
         end
         mv = ld ? 1'b1 : (mv && full_ext);
         @(posedge clk);
         #1;
         cyc++;
      end
      if (cyc >= 6000) begin
         n_cmp++; n_bad++;
         $display("FAIL rnd_timeout: %0d flits outstanding, want 0", expq.size());
      end
      full_ext = 1'b0; pkt_req = 1'b0; pl_val = 1'b0;
      @(negedge clk);
      chk1("rnd_end_busy", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/flit_tx_channel.md
Name: flit_tx_channel

Overview:
- Output-channel transmitter for the virtual channel router: packetizes a payload stream into header/body/tail flits.
- Drives them into the downstream router's 6-deep input FIFO through its din / in_val / full_ext interface.
- The other end of the input FIFO write port: one packet in flight, one-entry registered output stage, no bubbles under continuous traffic.

Parameters:
- SRC_ID, 4'd0, source router id placed in header bits [19:16].
- MAX_LEN, 16, max payload flits per packet; legal range 1..31.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- pkt_req  in  1  request to start a packet; held until pkt_ack.
- pkt_dest  in  4  destination router id, valid with pkt_req.
- pkt_len  in  5  payload flit count, valid with pkt_req.
- pkt_ack  out  1  one-cycle pulse: request consumed (accepted or rejected).
- err_len  out  1  one-cycle pulse with pkt_ack when pkt_len==0 or pkt_len>MAX_LEN.
- pl_data  in  29  payload word.
- pl_val  in  1  pl_data valid.
- pl_rdy  out  1  payload accepted on the edge where pl_val & pl_rdy.
- full_ext  in  1  downstream FIFO full, already synchronous to clk.
- dout  out  32  flit to downstream din, registered.
- in_val  out  1  flit valid to downstream, registered.
- busy  out  1  high while a packet is in progress or in_val=1.

Behaviour:
- Flit format:
  - [30:29] type: 01 header, 10 body, 11 tail, 00 never sent.
  - Header: [28:25] dest, [24:20] len, [19:16] SRC_ID, [15:0] zero.
  - Body/tail: [28:0] pl_data.
  - [31] is 0, except under the optional feature below.
- Transfer rule: a flit is delivered on a rising edge where in_val=1 and full_ext=0. While full_ext=1, dout and in_val hold unchanged.
- Output register free condition: out_free = !in_val | !full_ext (combinational). A new flit loads only when out_free; otherwise in_val clears after delivery.
- FSM IDLE:
  - pkt_req & out_free & legal len → load header, pkt_ack=1, latch cnt=pkt_len, go PAYLOAD.
  - Illegal len → pkt_ack=1 and err_len=1 for one cycle, nothing sent, stay IDLE.
  - pkt_req & !out_free → wait, no ack.
- FSM PAYLOAD:
  - pl_rdy = out_free.
  - On pl_val & pl_rdy: load flit, type 11 if cnt==1 else 10; cnt decrements.
  - Loading the tail → IDLE.
- Latency: pkt_req at edge N gives header on dout/in_val after edge N. Payload accepted at edge M appears after edge M.
- Back-to-back: a new header may load on the same edge the tail is delivered. A stream with full_ext=0 throughout sustains 1 flit/cycle.
- pkt_len=1 → header followed by one tail flit, no body.
- Reset values: in_val=0, dout=32'h0, pkt_ack=0, err_len=0, pl_rdy=0 during reset, busy=0, state IDLE, cnt=0.
- Reset mid-packet abandons the packet; the downstream FIFO is reset in the same cycle by the router.
- pkt_dest/pkt_len changes after pkt_ack are ignored until the next packet.

Optional Feature:
- Macro FLIT_PARITY_EN.
- Defined: dout[31] = even parity over dout[30:0] for every flit, computed when the flit is loaded.
- Undefined: dout[31] is constant 0 and no parity logic exists.

Decomposition:
- Shared package flit_pkg holds:
  - flit type codes: FLIT_HEAD=2'b01, FLIT_BODY=2'b10, FLIT_TAIL=2'b11.
  - field positions: TYPE_HI=30, TYPE_LO=29, DEST_HI=28, DEST_LO=25, LEN_HI=24, LEN_LO=20, SRC_HI=19, SRC_LO=16.
  - FIFO_DEPTH=6.
- One sub-module: flit_out_stage, the one-entry output register with load/hold/out_free logic and the optional parity.

Test Plan:
- pkt_dest=5, pkt_len=3, SRC_ID=2, pl_val always 1, full_ext=0 → dout sequence 0x2A320000 (header), body, body, tail with [30:29]=11; 4 consecutive in_val cycles; pkt_ack exactly once.
- full_ext=1 for 4 cycles while the first body flit is on dout → dout/in_val held 4 cycles, pl_rdy=0; no flit lost or duplicated after release.
- pkt_len=0, then pkt_len=20 → pkt_ack & err_len one-cycle pulses each, in_val stays 0.
- Two packets (len 1, then len 2) queued back-to-back with full_ext=0 → header,tail,header,body,tail on 5 consecutive cycles.
- reset asserted after the 2nd flit of a len-4 packet → next edge in_val=0, dout=0, busy=0; a following packet starts with a header.
- FLIT_PARITY_EN defined, pl_data=29'h1 → dout[31]=1 on tail flit (type 11 plus one data bit = odd → parity bit 1).
